// File: rtl/bist_if.sv
// BIST scheduler bus: session control, datapath strobes and results.
// master drives requests and signatures, slave is the scheduler.
interface bist_if #(
  parameter int NUM_CUT = 4,
  parameter int SIG_W   = 16,
  parameter int CW      = (NUM_CUT > 1) ? $clog2(NUM_CUT) : 1
);
  logic                     start;
  logic [NUM_CUT-1:0]       slot_mask;
  logic [NUM_CUT*SIG_W-1:0] golden_sig;
  logic [SIG_W-1:0]         sig_in;
  logic                     dp_stall;
  logic [CW-1:0]            cut_sel;
  logic                     dp_init;
  logic                     dp_run;
  logic                     busy;
  logic                     done;
  logic                     aborted;
  logic [NUM_CUT-1:0]       pass_vec;
  logic [NUM_CUT-1:0]       fail_vec;

  modport master (
    output start, slot_mask, golden_sig,
    output sig_in, dp_stall,
    input  cut_sel, dp_init, dp_run,
    input  busy, done, aborted,
    input  pass_vec, fail_vec
  );

  modport slave (
    input  start, slot_mask, golden_sig,
    input  sig_in, dp_stall,
    output cut_sel, dp_init, dp_run,
    output busy, done, aborted,
    output pass_vec, fail_vec
  );
endinterface

// File: rtl/bist_scheduler.sv
// Sequences CUTs through a shared BIST datapath and collects pass/fail.
// Define BIST_STOP_ON_FAIL_EN to end the session on the first mismatch.
module bist_scheduler #(
  parameter int NUM_CUT = 4,
  parameter int NCLOCK  = 5,
  parameter int SIG_W   = 16
) (
  input logic  clk,
  input logic  reset,
  bist_if.slave bus
);
  localparam int CW = (NUM_CUT > 1) ? $clog2(NUM_CUT) : 1;
  localparam logic [7:0] LAST = 8'(NCLOCK - 1);

  typedef enum logic [2:0] {
    IDLE, SEL, INIT, RUN, CHECK, DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cut_sel;
  logic [NUM_CUT-1:0] mask;
  logic [7:0]         cnt;
  logic               dp_init;
  logic               busy;
  logic               done;
  logic [NUM_CUT-1:0] pass_q;
  logic [NUM_CUT-1:0] fail_q;

  logic [CW-1:0] first_idx;
  logic [CW-1:0] next_idx;
  logic          next_ok;
  logic          match;
  logic          halt;

  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    next_ok   = 1'b0;
    // Walk downward so the lowest qualifying bit wins.
    for (int i = NUM_CUT - 1; i >= 0; i--) begin
      if (bus.slot_mask[i])
        first_idx = CW'(i);
      if (mask[i] && i > int'(cut_sel)) begin
        next_idx = CW'(i);
        next_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    match = bus.sig_in ==
      bus.golden_sig[int'(cut_sel)*SIG_W +: SIG_W];
`ifdef BIST_STOP_ON_FAIL_EN
    halt = !match;
`else
    halt = 1'b0;
`endif
  end

`ifdef BIST_STOP_ON_FAIL_EN
  logic abort_q;
  assign bus.aborted = abort_q;
`else
  assign bus.aborted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cut_sel <= '0;
      mask    <= '0;
      cnt     <= '0;
      dp_init <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
`ifdef BIST_STOP_ON_FAIL_EN
      abort_q <= 1'b0;
`endif
    end else begin
      dp_init <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mask   <= bus.slot_mask;
            pass_q <= '0;
            fail_q <= '0;
            busy   <= 1'b1;
`ifdef BIST_STOP_ON_FAIL_EN
            abort_q <= 1'b0;
`endif
            if (|bus.slot_mask) begin
              cut_sel <= first_idx;
              state   <= SEL;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        SEL: begin
          dp_init <= 1'b1;
          state   <= INIT;
        end
        INIT: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (!bus.dp_stall) begin
            cnt <= cnt + 8'd1;
            if (cnt == LAST)
              state <= CHECK;
          end
        end
        CHECK: begin
          if (match)
            pass_q[cut_sel] <= 1'b1;
          else
            fail_q[cut_sel] <= 1'b1;
`ifdef BIST_STOP_ON_FAIL_EN
          if (halt)
            abort_q <= 1'b1;
`endif
          if (next_ok && !halt) begin
            cut_sel <= next_idx;
            state   <= SEL;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cut_sel  = cut_sel;
  assign bus.dp_init  = dp_init;
  assign bus.dp_run   = (state == RUN) && !bus.dp_stall;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pass_vec = pass_q;
  assign bus.fail_vec = fail_q;
endmodule

// File: tb/tb_bist_scheduler.sv
// Self-checking bench for bist_scheduler: directed and random sessions
// against a cycle-budget model of the scheduling rules.
module tb_bist_scheduler;
  localparam int NUM_CUT = 4;
  localparam int NCLOCK  = 5;
  localparam int SIG_W   = 16;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  logic [NUM_CUT*SIG_W-1:0] golden;
  logic [NUM_CUT-1:0]       bad;
  bit                       stl [1024];

  bist_if #(.NUM_CUT(NUM_CUT), .SIG_W(SIG_W)) bus ();

  bist_scheduler #(
    .NUM_CUT(NUM_CUT),
    .NCLOCK (NCLOCK),
    .SIG_W  (SIG_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.golden_sig = golden;

  always_comb begin
    logic [SIG_W-1:0] s;
    s = golden[int'(bus.cut_sel)*SIG_W +: SIG_W];
    if (bad[bus.cut_sel])
      s = s ^ 16'h5a5a;
    bus.sig_in = s;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Timeline model: per CUT one SEL, one INIT, NCLOCK
  // non-stalled RUN cycles, one CHECK; then one DONE cycle.
  function automatic void model(
    input  logic [3:0] m,
    input  logic [3:0] b,
    output int         done_c,
    output int         tested,
    output logic [3:0] ep,
    output logic [3:0] ef,
    output logic       ea
  );
    int c;
    int k;
    c = 0;
    tested = 0;
    ep = '0;
    ef = '0;
    ea = 1'b0;
    for (int i = 0; i < NUM_CUT; i++) begin
      if (m[i] && !ea) begin
        c += 2;
        k = 0;
        while (k < NCLOCK) begin
          c++;
          if (!stl[c]) k++;
        end
        c++;
        tested++;
        if (b[i]) begin
          ef[i] = 1'b1;
`ifdef BIST_STOP_ON_FAIL_EN
          ea = 1'b1;
`endif
        end else begin
          ep[i] = 1'b1;
        end
      end
    end
    done_c = c + 1;
  endfunction

  task automatic session(input logic [3:0] m,
                         input logic [3:0] b,
                         input string tag);
    int done_c;
    int tested;
    logic [3:0] ep;
    logic [3:0] ef;
    logic ea;
    int got_done;
    int runs;
    int inits;
    model(m, b, done_c, tested, ep, ef, ea);
    bad = b;
    @(negedge clk);
    bus.dp_stall  = 1'b0;
    bus.slot_mask = m;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.slot_mask = 4'($urandom);
    got_done = -1;
    runs  = 0;
    inits = 0;
    for (int c = 1; c < 1000 && got_done < 0; c++) begin
      @(negedge clk);
      bus.dp_stall = stl[c];
      #1;
      if (c == 1) check({tag, ".busy"}, 64'(bus.busy), 64'd1);
      if (bus.dp_run)  runs++;
      if (bus.dp_init) inits++;
      if (bus.done)    got_done = c;
    end
    bus.dp_stall = 1'b0;
    check({tag, ".done_cyc"}, 64'(got_done), 64'(done_c));
    check({tag, ".runs"}, 64'(runs), 64'(tested * NCLOCK));
    check({tag, ".inits"}, 64'(inits), 64'(tested));
    check({tag, ".pass"}, 64'(bus.pass_vec), 64'(ep));
    check({tag, ".fail"}, 64'(bus.fail_vec), 64'(ef));
    check({tag, ".abort"}, 64'(bus.aborted), 64'(ea));
    @(negedge clk);
    #1;
    check({tag, ".idle"}, 64'({bus.busy, bus.done}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check({tag, ".hold"},
          64'({bus.pass_vec, bus.fail_vec}), 64'({ep, ef}));
  endtask

  task automatic clear_stall();
    for (int i = 0; i < 1024; i++) stl[i] = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    golden = {$urandom, $urandom};
    bad = '0;
    clear_stall();
    bus.start     = 1'b0;
    bus.slot_mask = '0;
    bus.dp_stall  = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.outs",
          64'({bus.cut_sel, bus.dp_init, bus.dp_run,
               bus.busy, bus.done, bus.aborted}), 64'd0);
    check("rst.vecs",
          64'({bus.pass_vec, bus.fail_vec}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    session(4'b0101, 4'b0000, "two_cut");

    stl[4] = 1'b1;
    stl[5] = 1'b1;
    stl[6] = 1'b1;
    session(4'b0001, 4'b0000, "stall3");
    clear_stall();

    session(4'b1111, 4'b0010, "fail_cut1");
    session(4'b0000, 4'b0000, "empty");

    for (int r = 0; r < 10; r++) begin
      golden = {$urandom, $urandom};
      for (int i = 1; i < 1024; i++)
        stl[i] = ($urandom_range(0, 3) == 0);
      session(4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), "rand");
    end
    clear_stall();

    golden = {$urandom, $urandom};
    bad = '0;
    @(negedge clk);
    bus.slot_mask = 4'b1111;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 10) begin
        bus.start     = 1'b1;
        bus.slot_mask = 4'b0001;
      end
      if (c == 11) bus.start = 1'b0;
      if (c == 19) begin
        #1;
        check("busy_start.pass", 64'(bus.pass_vec), 64'h3);
        check("busy_start.sel", 64'(bus.cut_sel), 64'd2);
      end
      if (c == 20) begin
        reset     = 1'b0;
        bus.start = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    check("midrst.outs",
          64'({bus.cut_sel, bus.dp_init, bus.dp_run,
               bus.busy, bus.done, bus.aborted}), 64'd0);
    check("midrst.vecs",
          64'({bus.pass_vec, bus.fail_vec}), 64'd0);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midrst.idle", 64'({bus.busy, bus.dp_init}), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/bist_scheduler.md
BIST_SCHEDULER -- requirements
Module: bist_scheduler

Interface
REQ-001 SHALL have parameter NUM_CUT, default 4: number of circuits under test sharing one BIST datapath.
REQ-002 SHALL have parameter NCLOCK, default 5: run cycles per CUT, range 1..255.
REQ-003 SHALL have parameter SIG_W, default 16: signature width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  session request, sampled in IDLE only.
REQ-007 SHALL have port slot_mask  input  NUM_CUT  CUTs to test, latched on accepted start.
REQ-008 SHALL have port golden_sig  input  NUM_CUT*SIG_W  expected signatures; slice i = bits [i*SIG_W +: SIG_W].
REQ-009 SHALL have port sig_in  input  SIG_W  datapath signature, valid in CHECK.
REQ-010 SHALL have port dp_stall  input  1  datapath stall request during RUN.
REQ-011 SHALL have port cut_sel  output  clog2(NUM_CUT)  index of the CUT owning the datapath.
REQ-012 SHALL have port dp_init  output  1  datapath init strobe (LFSR/MISR seed).
REQ-013 SHALL have port dp_run  output  1  datapath advance enable.
REQ-014 SHALL have ports busy, done, aborted  output  1 each  status; done is a one-cycle pulse.
REQ-015 SHALL have ports pass_vec, fail_vec  output  NUM_CUT each  per-CUT result.

Function
REQ-016 SHALL implement states IDLE, SEL, INIT, RUN, CHECK, DONE.
REQ-017 SHALL, in IDLE with start=1 and slot_mask!=0, latch the mask, clear pass_vec/fail_vec/aborted, and enter SEL with cut_sel = lowest set mask bit.
REQ-018 SHALL, in IDLE with start=1 and slot_mask==0, clear results and enter DONE directly.
REQ-019 SHALL ignore start and slot_mask changes outside IDLE.
REQ-020 SHALL stay one cycle in SEL, then one cycle in INIT with dp_init=1, then enter RUN with the run counter at 0.
REQ-021 SHALL, in RUN, drive dp_run = !dp_stall and increment the counter only on non-stalled cycles; the cycle the counter reaches NCLOCK-1 while not stalled, it SHALL go to CHECK.
REQ-022 SHALL, in CHECK, set pass_vec[cut_sel] if sig_in equals golden slice cut_sel, else set fail_vec[cut_sel].
REQ-023 SHALL, leaving CHECK, go to SEL with cut_sel = next higher set mask bit, or to DONE if none remains.
REQ-024 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-025 SHALL drive busy=1 in every state except IDLE.
REQ-026 SHALL hold cut_sel constant from SEL through CHECK of a slot, and in IDLE/DONE keep the last value.
REQ-027 SHALL hold pass_vec, fail_vec and aborted from DONE until the next accepted start.
REQ-028 SHALL give latency, with no stalls, of NCLOCK+3 cycles per enabled CUT plus one DONE cycle.
REQ-029 SHALL never set both pass_vec[i] and fail_vec[i], and never set either for an unmasked CUT.

Reset
REQ-030 SHALL, with reset=0 at a rising edge, enter IDLE regardless of state, abandoning any session.
REQ-031 SHALL, after reset, drive cut_sel=0, dp_init=0, dp_run=0, busy=0, done=0, aborted=0, pass_vec=0, fail_vec=0, and clear the run counter and latched mask.

Configuration
REQ-032 SHALL, with macro BIST_STOP_ON_FAIL_EN defined, go from CHECK to DONE on a signature mismatch and set aborted=1; remaining slots stay untested with pass/fail bits 0.
REQ-033 SHALL, with BIST_STOP_ON_FAIL_EN undefined, test all masked slots regardless of failures and tie aborted to 0.

Verification
REQ-034 SHALL cover: NCLOCK=5, mask=4'b0101, all signatures match, no stall, start accepted at edge 0 -> dp_run high for cycles 3-7 and 11-15, done at cycle 17, pass_vec=4'b0101, fail_vec=0.
REQ-035 SHALL cover: mask=4'b0001, dp_stall high for 3 cycles mid-RUN -> exactly 5 dp_run cycles, done delayed by 3 cycles (cycle 12), pass_vec=4'b0001.
REQ-036 SHALL cover: mask=4'b1111, sig mismatch on CUT1 -> without macro: pass_vec=4'b1101, fail_vec=4'b0010, aborted=0; with BIST_STOP_ON_FAIL_EN: pass_vec=4'b0001, fail_vec=4'b0010, aborted=1.
REQ-037 SHALL cover: start with mask=0 -> done one cycle later, no dp_init or dp_run pulse, pass_vec=fail_vec=0.
REQ-038 SHALL cover: reset=0 asserted during RUN of CUT2, then start re-pulsed while busy is 1 -> next cycle IDLE with all outputs at reset values; re-pulsed start during busy has no effect.
